mixffn_weight_streamer: RTL and testbench

Parametrised weight/bias sequencer for the MixFFN pipeline (fc1 → dwconv → GELU → fc2). It holds one layer's weight table and, while the upstream stage requests it, presents one full lane vector per cycle in the order that layer consumes. The cycle offset walks the pattern and wraps. One instance per layer replaces bench-side weight driving: fc1 uses strided order, fc2 uses strided order, dwconv uses contiguous order with a per-channel bias.

---
 rtl/mixffn_weight_streamer.sv | 205 ++++++++++++++++++++
 tb/tb_mixffn_weight_streamer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mixffn_weight_streamer.sv
// mixffn_weight_streamer
//   Holds one MixFFN layer's weight table and, while upstream requests it,
//   presents one full lane vector per cycle in that layer's consumption order.
//   The cycle offset walks 0..PATTERN_LEN-1 and wraps.
//
// Optional feature macro: MIXFFN_WS_BIAS_EN
//   When defined, a PATTERN_LEN x BIAS_W bias table sits above the weight
//   table in the write address space. A bias_o port presents the entry for
//   the emitted offset.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   wr_en_i      table write strobe (accepted in EMPTY/READY)
//   wr_addr_i    table write address (bias entries at >= DEPTH when enabled)
//   wr_data_i    signed weight to store
//   load_done_i  table complete, enter READY
//   mode_i       0 = strided, 1 = contiguous (latched on READY->STREAM)
//   req_i        level request from upstream
//   restart_i    force offset to 0
//   w_valid_o    weight vector valid
//   weight_o     lane j at bits [j*WGT_W +: WGT_W]
//   offset_o     offset of the presented vector
//   wrap_o       high with the vector at offset PATTERN_LEN-1
//   bias_o       bias for the presented offset (bias build only)
//   err_o        sticky protocol-error flag, cleared only by rst_i
//
// States
//   EMPTY  | after reset, table not yet declared complete
//   READY  | table loaded, idle; writes allowed
//   STREAM | emitting one vector per requested cycle; writes rejected
module mixffn_weight_streamer #(
  parameter int LANES       = 256,
  parameter int WGT_W       = 9,
  parameter int PATTERN_LEN = 64,
  parameter int BIAS_W      = 16,
  localparam int DEPTH      = LANES * PATTERN_LEN,
`ifdef MIXFFN_WS_BIAS_EN
  localparam int ADDR_W     = $clog2(DEPTH + PATTERN_LEN),
`else
  localparam int ADDR_W     = $clog2(DEPTH),
`endif
  localparam int OFF_W      = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_en_i,
  input  logic [ADDR_W-1:0]         wr_addr_i,
  input  logic signed [WGT_W-1:0]   wr_data_i,
  input  logic                      load_done_i,
  input  logic                      mode_i,
  input  logic                      req_i,
  input  logic                      restart_i,
  output logic                      w_valid_o,
  output logic [LANES*WGT_W-1:0]    weight_o,
  output logic [OFF_W-1:0]          offset_o,
  output logic                      wrap_o,
`ifdef MIXFFN_WS_BIAS_EN
  output logic signed [BIAS_W-1:0]  bias_o,
`endif
  output logic                      err_o
);

  localparam int TBL_AW = $clog2(DEPTH);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(PATTERN_LEN - 1);

  if (LANES < 1 || PATTERN_LEN < 2 || WGT_W < 1 || BIAS_W < 1) begin : g_param_chk
    $error("mixffn_weight_streamer: illegal parameter set");
  end

  typedef enum logic [1:0] {ST_EMPTY, ST_READY, ST_STREAM} state_e;

  state_e                    state_q;
  logic                      mode_q;
  logic [OFF_W-1:0]          off_q;
  logic                      w_valid_q;
  logic [LANES*WGT_W-1:0]    weight_q;
  logic [OFF_W-1:0]          offset_q;
  logic                      wrap_q;
  logic                      err_q;

  logic signed [WGT_W-1:0]   wgt_mem_q [DEPTH];

  // Write decode. One extra address bit keeps the compare exact even when
  // DEPTH is a power of two and does not fit in ADDR_W bits.
  logic [ADDR_W:0] addr_x;
  logic            wgt_hit;
  logic            addr_bad;
  logic            wr_ok;
  logic            wr_err;

  assign addr_x  = {1'b0, wr_addr_i};
  assign wgt_hit = addr_x < (ADDR_W + 1)'(DEPTH);

`ifdef MIXFFN_WS_BIAS_EN
  logic                      bias_hit;
  logic signed [BIAS_W-1:0]  bias_mem_q [PATTERN_LEN];
  logic signed [BIAS_W-1:0]  bias_q;
  logic [OFF_W-1:0]          bias_widx;
  logic signed [BIAS_W-1:0]  bias_wdata;

  assign bias_hit   = !wgt_hit && (addr_x < (ADDR_W + 1)'(DEPTH + PATTERN_LEN));
  assign addr_bad   = !(wgt_hit || bias_hit);
  assign bias_widx  = OFF_W'(wr_addr_i - ADDR_W'(DEPTH));
  // Sized cast of a signed operand sign-extends (or keeps the low bits).
  assign bias_wdata = BIAS_W'(wr_data_i);
`else
  assign addr_bad   = !wgt_hit;
`endif

  assign wr_ok  = wr_en_i && (state_q != ST_STREAM) && !addr_bad;
  assign wr_err = wr_en_i && ((state_q == ST_STREAM) || addr_bad);

  always_ff @(posedge clk_i) begin
    if (wr_ok && wgt_hit) begin
      wgt_mem_q[TBL_AW'(wr_addr_i)] <= wr_data_i;
    end
`ifdef MIXFFN_WS_BIAS_EN
    if (wr_ok && bias_hit) begin
      bias_mem_q[bias_widx] <= bias_wdata;
    end
`endif
  end

  // Emission path. The vector leaving on the READY->STREAM edge already uses
  // the mode being latched, so the comb side looks at mode_i in READY.
  logic                    emit;
  logic                    mode_eff;
  logic [OFF_W-1:0]        off_emit;
  logic [OFF_W-1:0]        off_next;
  logic [LANES*WGT_W-1:0]  lanes_d;

  assign emit     = req_i && (state_q != ST_EMPTY);
  assign mode_eff = (state_q == ST_READY) ? mode_i : mode_q;
  assign off_emit = restart_i ? '0 : off_q;
  assign off_next = (off_emit == OFF_LAST) ? '0 : off_emit + 1'b1;

  always_comb begin
    lanes_d = '0;
    for (int j = 0; j < LANES; j++) begin
      lanes_d[j*WGT_W +: WGT_W] = wgt_mem_q[TBL_AW'(mode_eff
                                   ? (int'(off_emit) * LANES + j)
                                   : (j * PATTERN_LEN + int'(off_emit)))];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_EMPTY;
      mode_q    <= 1'b0;
      off_q     <= '0;
      w_valid_q <= 1'b0;
      weight_q  <= '0;
      offset_q  <= '0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef MIXFFN_WS_BIAS_EN
      bias_q    <= '0;
`endif
    end else begin
      w_valid_q <= 1'b0;
      wrap_q    <= 1'b0;

      if (wr_err || (req_i && state_q == ST_EMPTY)) begin
        err_q <= 1'b1;
      end

      if (restart_i) begin
        off_q <= '0;
      end

      case (state_q)
        ST_EMPTY:  if (load_done_i) state_q <= ST_READY;
        ST_READY:  if (req_i) begin
                     state_q <= ST_STREAM;
                     mode_q  <= mode_i;
                   end
        ST_STREAM: if (!req_i) state_q <= ST_READY;
        default:   state_q <= ST_EMPTY;
      endcase

      // weight_q and offset_q hold when req drops; only valid/wrap fall.
      if (emit) begin
        w_valid_q <= 1'b1;
        weight_q  <= lanes_d;
        offset_q  <= off_emit;
        wrap_q    <= (off_emit == OFF_LAST);
        off_q     <= off_next;
`ifdef MIXFFN_WS_BIAS_EN
        bias_q    <= bias_mem_q[off_emit];
`endif
      end
    end
  end

  assign w_valid_o = w_valid_q;
  assign weight_o  = weight_q;
  assign offset_o  = offset_q;
  assign wrap_o    = wrap_q;
  assign err_o     = err_q;
`ifdef MIXFFN_WS_BIAS_EN
  assign bias_o    = bias_q;
`endif

endmodule

// File: tb/tb_mixffn_weight_streamer.sv
module tb_mixffn_weight_streamer;

  localparam int LANES = 4;
  localparam int WGT_W = 8;
  localparam int PL    = 3;
  localparam int BIAS_W = 16;
  localparam int DEPTH = LANES * PL;
`ifdef MIXFFN_WS_BIAS_EN
  localparam int ADDR_W = $clog2(DEPTH + PL);
  localparam int WLIM   = DEPTH + PL;
`else
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int WLIM   = DEPTH;
`endif
  localparam int OFF_W = $clog2(PL);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [WGT_W-1:0]  wr_data;
  logic                     load_done;
  logic                     mode;
  logic                     req;
  logic                     restart;
  logic                     w_valid_o;
  logic [LANES*WGT_W-1:0]   weight_o;
  logic [OFF_W-1:0]         offset_o;
  logic                     wrap_o;
  logic                     err_o;
`ifdef MIXFFN_WS_BIAS_EN
  logic signed [BIAS_W-1:0] bias_o;
`endif

  mixffn_weight_streamer #(
    .LANES(LANES), .WGT_W(WGT_W), .PATTERN_LEN(PL), .BIAS_W(BIAS_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .load_done_i(load_done), .mode_i(mode),
    .req_i(req), .restart_i(restart), .w_valid_o(w_valid_o),
    .weight_o(weight_o), .offset_o(offset_o), .wrap_o(wrap_o),
`ifdef MIXFFN_WS_BIAS_EN
    .bias_o(bias_o),
`endif
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LANES*WGT_W-1:0] w;
    logic [OFF_W-1:0]       off;
    logic                   wrap;
    logic [BIAS_W-1:0]      b;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model of the block's observable behaviour.
  logic signed [WGT_W-1:0]  tbl  [DEPTH];
  logic signed [BIAS_W-1:0] btbl [PL];
  int                       m_st;    // 0 empty, 1 ready, 2 stream
  int                       m_off;
  logic                     m_mode;
  logic                     m_err;
  logic                     exp_v;
  logic [LANES*WGT_W-1:0]   last_w;

  function automatic logic [LANES*WGT_W-1:0] vec(input logic md, input int o);
    logic [LANES*WGT_W-1:0] v;
    v = '0;
    for (int j = 0; j < LANES; j++)
      v[j*WGT_W +: WGT_W] = tbl[md ? (o*LANES + j) : (j*PL + o)];
    return v;
  endfunction

  task automatic drive(input logic r, input logic rs, input logic we,
                       input int wa, input int wd, input logic ld);
    exp_t e;
    int   o;
    int   st0;
    @(negedge clk);
    req = r; restart = rs; wr_en = we; load_done = ld;
    wr_addr = ADDR_W'(wa); wr_data = WGT_W'(wd);
    st0 = m_st;
    exp_v = 1'b0;
    if (r && m_st != 0) begin
      if (m_st == 1) m_mode = mode;
      o = rs ? 0 : m_off;
      e.w = vec(m_mode, o);
      e.off = OFF_W'(o);
      e.wrap = (o == PL-1);
      e.b = btbl[o];
      sb.push_back(e);
      last_w = e.w;
      exp_v = 1'b1;
      m_off = (o == PL-1) ? 0 : o + 1;
      m_st = 2;
    end else begin
      if (r) m_err = 1'b1;
      if (rs) m_off = 0;
      if (m_st == 2) m_st = 1;
      else if (m_st == 0 && ld) m_st = 1;
    end
    if (we) begin
      if (st0 == 2 || wa >= WLIM) m_err = 1'b1;
      else if (wa < DEPTH) tbl[wa] = WGT_W'(wd);
      else btbl[wa-DEPTH] = BIAS_W'(wd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 0; restart = 0; wr_en = 0; load_done = 0;
    m_st = 0; m_off = 0; m_err = 1'b0; sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_cmp++;
    if ({w_valid_o, weight_o, offset_o, wrap_o, err_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b w=%h off=%0d wrap=%b err=%b want all zero",
               w_valid_o, weight_o, offset_o, wrap_o, err_o);
    end
`ifdef MIXFFN_WS_BIAS_EN
    n_cmp++;
    if (bias_o !== '0) begin n_bad++; $display("FAIL reset_bias: got %h want 0", bias_o); end
`endif
    @(negedge clk); rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (w_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_idle_valid: got %b want 0", w_valid_o); end
  endtask

  task automatic test_req_empty();
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 0, 0, 0);
      n_cmp++;
      if (w_valid_o !== 1'b0) begin n_bad++; $display("FAIL empty_req_valid: got %b want 0", w_valid_o); end
    end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (err_o !== 1'b1) begin n_bad++; $display("FAIL empty_req_err: got %b want 1", err_o); end
  endtask

  task automatic test_load();
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 1, i, i, 0);
    drive(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (err_o !== 1'b0) begin n_bad++; $display("FAIL load_err: got %b want 0", err_o); end
  endtask

  task automatic test_strided();
    logic [LANES*WGT_W-1:0] lit [3];
    exp_t e;
    lit[0] = 32'h09060300; lit[1] = 32'h0A070401; lit[2] = 32'h0B080502;
    mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0, 0);
      n_cmp++;
      if (w_valid_o !== exp_v) begin n_bad++; $display("FAIL strided_valid: got %b want %b", w_valid_o, exp_v); end
      if (exp_v) begin
        e = sb.pop_front();
        n_cmp++;
        if ({weight_o, offset_o, wrap_o} !== {e.w, e.off, e.wrap}) begin
          n_bad++;
          $display("FAIL strided_vec: got w=%h off=%0d wrap=%b want w=%h off=%0d wrap=%b",
                   weight_o, offset_o, wrap_o, e.w, e.off, e.wrap);
        end
      end
      n_cmp++;
      if (weight_o !== lit[k]) begin n_bad++; $display("FAIL strided_lit%0d: got %h want %h", k, weight_o, lit[k]); end
    end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({w_valid_o, weight_o} !== {1'b0, last_w}) begin
      n_bad++;
      $display("FAIL strided_drop: got v=%b w=%h want v=0 w=%h", w_valid_o, weight_o, last_w);
    end
  endtask

  task automatic test_contiguous();
    exp_t e;
    mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, 0, 0);
      n_cmp++;
      if (w_valid_o !== exp_v) begin n_bad++; $display("FAIL contig_valid: got %b want %b", w_valid_o, exp_v); end
      if (exp_v) begin
        e = sb.pop_front();
        n_cmp++;
        if ({weight_o, offset_o, wrap_o} !== {e.w, e.off, e.wrap}) begin
          n_bad++;
          $display("FAIL contig_vec%0d: got w=%h off=%0d wrap=%b want w=%h off=%0d wrap=%b",
                   k, weight_o, offset_o, wrap_o, e.w, e.off, e.wrap);
        end
      end
    end
    n_cmp++;
    if (weight_o !== 32'h03020100) begin n_bad++; $display("FAIL contig_wrap_lit: got %h want 03020100", weight_o); end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_pause();
    exp_t e;
    logic pat [8] = '{1, 1, 0, 0, 0, 0, 0, 1};
    drive(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      drive(pat[k], 0, 0, 0, 0, 0);
      n_cmp++;
      if (w_valid_o !== exp_v) begin n_bad++; $display("FAIL pause_valid%0d: got %b want %b", k, w_valid_o, exp_v); end
      if (exp_v) begin
        e = sb.pop_front();
        n_cmp++;
        if ({weight_o, offset_o, wrap_o} !== {e.w, e.off, e.wrap}) begin
          n_bad++;
          $display("FAIL pause_vec%0d: got w=%h off=%0d wrap=%b want w=%h off=%0d wrap=%b",
                   k, weight_o, offset_o, wrap_o, e.w, e.off, e.wrap);
        end
      end
    end
    n_cmp++;
    if (offset_o !== 2'd2) begin n_bad++; $display("FAIL pause_resume_off: got %0d want 2", offset_o); end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_restart();
    exp_t e;
    logic rs_pat [4] = '{0, 0, 1, 0};
    for (int k = 0; k < 4; k++) begin
      drive(1, rs_pat[k], 0, 0, 0, 0);
      n_cmp++;
      if (w_valid_o !== exp_v) begin n_bad++; $display("FAIL restart_valid: got %b want %b", w_valid_o, exp_v); end
      if (exp_v) begin
        e = sb.pop_front();
        n_cmp++;
        if ({weight_o, offset_o, wrap_o} !== {e.w, e.off, e.wrap}) begin
          n_bad++;
          $display("FAIL restart_vec%0d: got w=%h off=%0d wrap=%b want w=%h off=%0d wrap=%b",
                   k, weight_o, offset_o, wrap_o, e.w, e.off, e.wrap);
        end
      end
      if (k == 2) begin
        n_cmp++;
        if ({offset_o, wrap_o} !== {2'd0, 1'b0}) begin
          n_bad++;
          $display("FAIL restart_collision: got off=%0d wrap=%b want off=0 wrap=0", offset_o, wrap_o);
        end
      end
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  // Write at one edge, read it with a request on the next; negative value checks sign.
  task automatic test_write_latency();
    exp_t e;
    mode = 1'b1;
    drive(0, 1, 1, 1, -7, 0);
    drive(1, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    n_cmp++;
    if ({w_valid_o, weight_o, offset_o} !== {1'b1, e.w, e.off}) begin
      n_bad++;
      $display("FAIL wr_then_rd: got v=%b w=%h off=%0d want v=1 w=%h off=%0d",
               w_valid_o, weight_o, offset_o, e.w, e.off);
    end
    n_cmp++;
    if (weight_o !== 32'h0302F900) begin n_bad++; $display("FAIL wr_sign_lit: got %h want 0302f900", weight_o); end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stream_write();
    exp_t e;
    mode = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 2, 8'h55, 0);
    n_cmp++;
    if (err_o !== 1'b1) begin n_bad++; $display("FAIL stream_wr_err: got %b want 1", err_o); end
    sb.delete();
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    n_cmp++;
    if (weight_o !== e.w) begin n_bad++; $display("FAIL stream_wr_dropped: got %h want %h", weight_o, e.w); end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_rst_midburst();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({w_valid_o, weight_o, offset_o, wrap_o, err_o} !== '0) begin
      n_bad++;
      $display("FAIL midburst_rst: got v=%b w=%h off=%0d wrap=%b err=%b want all zero",
               w_valid_o, weight_o, offset_o, wrap_o, err_o);
    end
    m_st = 0; m_off = 0; m_err = 1'b0; sb.delete();
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 0, 0, 0);
      n_cmp++;
      if (w_valid_o !== 1'b0) begin n_bad++; $display("FAIL after_rst_empty: got v=%b want 0", w_valid_o); end
    end
    n_cmp++;
    if (err_o !== 1'b1) begin n_bad++; $display("FAIL after_rst_err: got %b want 1", err_o); end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_bad_addr();
    do_reset();
    drive(0, 0, 1, WLIM-1, 11, 0);
    n_cmp++;
    if (err_o !== 1'b0) begin n_bad++; $display("FAIL top_addr_err: got %b want 0", err_o); end
    if (WLIM < (1 << ADDR_W)) begin
      drive(0, 0, 1, WLIM, 5, 0);
      drive(0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (err_o !== m_err) begin n_bad++; $display("FAIL oob_addr_err: got %b want %b", err_o, m_err); end
    end
  endtask

`ifdef MIXFFN_WS_BIAS_EN
  task automatic test_bias();
    exp_t e;
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(0, 0, 1, i, i, 0);
    for (int k = 0; k < PL; k++) drive(0, 0, 1, DEPTH + k, -k, 0);
    drive(0, 0, 0, 0, 0, 1);
    mode = 1'b1;
    for (int k = 0; k < PL; k++) begin
      drive(1, 0, 0, 0, 0, 0);
      e = sb.pop_front();
      n_cmp++;
      if ({w_valid_o, offset_o, bias_o} !== {1'b1, e.off, e.b}) begin
        n_bad++;
        $display("FAIL bias_vec%0d: got v=%b off=%0d bias=%0d want v=1 off=%0d bias=%0d",
                 k, w_valid_o, offset_o, bias_o, e.off, $signed(e.b));
      end
      n_cmp++;
      if (bias_o !== BIAS_W'(-k)) begin n_bad++; $display("FAIL bias_lit%0d: got %0d want %0d", k, bias_o, -k); end
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask
`endif

  initial begin
    rst = 1'b1; wr_en = 0; wr_addr = '0; wr_data = '0; load_done = 0;
    mode = 0; req = 0; restart = 0;
    m_st = 0; m_off = 0; m_mode = 1'b0; m_err = 1'b0; exp_v = 1'b0; last_w = '0;
    for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
    for (int k = 0; k < PL; k++) btbl[k] = '0;

    test_reset();
    test_req_empty();
    do_reset();
    test_load();
    test_strided();
    test_contiguous();
    test_pause();
    test_restart();
    test_write_latency();
    test_stream_write();
    test_rst_midburst();
    test_bad_addr();
`ifdef MIXFFN_WS_BIAS_EN
    test_bias();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
